// File: rtl/detector_coincidence_counter_if.sv
// Result stream between the coincidence counter and its consumer.
//   tdata  : 64-bit result word {gate_idx, cnt_ab, cnt_b, cnt_a}
//   tvalid : result word valid
//   tready : consumer ready
interface detector_coincidence_counter_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/detector_coincidence_counter.sv
// Gated rate and coincidence counter. Counts rising edges on two detector
// channels and their coincidences over a programmable gate of N+1 cycles and
// emits one result word per gate on a single-entry stream register. Words
// that find the register occupied are dropped and counted.
//   aclk, aresetn : clock, asynchronous active-low reset
//   test          : channel levels, bit 0 = A, bit 1 = B
//   cfg           : {run, N}; gate length is N+1 cycles
//   m_axis        : result stream (master side)
//   sts           : dropped-word count, saturating
module detector_coincidence_counter #(
    parameter int unsigned GATE_WIDTH = 32
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [1:0]                       test,
    input  logic [GATE_WIDTH:0]              cfg,
    detector_coincidence_counter_if.master   m_axis,
    output logic [15:0]                      sts
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              test_q;
    logic [GATE_WIDTH-1:0]   gate_cntr_q, gate_cntr_d;
    logic [CNT_W-1:0]        cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]        cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0]        cnt_ab_q, cnt_ab_d;
    logic [CNT_W-1:0]        gate_idx_q, gate_idx_d;
    logic [WORD_W-1:0]       tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic [CNT_W-1:0]        sts_q, sts_d;

    logic                    run;
    logic [GATE_WIDTH-1:0]   gate_n;
    logic                    rise_a, rise_b, rise_ab;
    logic [CNT_W-1:0]        cnt_a_nxt, cnt_b_nxt, cnt_ab_nxt;
    logic                    gate_end;
    logic                    handshake;

    // Saturating increment; counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    assign run    = cfg[GATE_WIDTH];
    assign gate_n = cfg[GATE_WIDTH-1:0];

    // Edge detection against the previous-cycle levels.
    assign rise_a  = test[0] & ~test_q[0];
    assign rise_b  = test[1] & ~test_q[1];
    assign rise_ab = (test[0] & test[1]) & ~(test_q[0] & test_q[1]);

    // Counter values including this cycle's rises; also the result payload at gate end.
    assign cnt_a_nxt  = sat_inc(cnt_a_q,  rise_a);
    assign cnt_b_nxt  = sat_inc(cnt_b_q,  rise_b);
    assign cnt_ab_nxt = sat_inc(cnt_ab_q, rise_ab);

    // Run low wins over gate end: a gate interrupted on its last cycle yields no word.
    assign gate_end  = (state_q == COUNT) && run && (gate_cntr_q == gate_n);
    assign handshake = tvalid_q & m_axis.tready;

    // Next-state logic for gate control, counters and output register.
    always_comb begin
        state_d     = state_q;
        gate_cntr_d = gate_cntr_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        cnt_ab_d    = cnt_ab_q;
        gate_idx_d  = gate_idx_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        sts_d       = sts_q;

        if (state_q == IDLE) begin
            gate_cntr_d = '0;
            cnt_a_d     = '0;
            cnt_b_d     = '0;
            cnt_ab_d    = '0;
            if (run) begin
                state_d    = COUNT;
                gate_idx_d = '0;
            end
        end else if (!run) begin
            // Partial gate is discarded silently.
            state_d     = IDLE;
            gate_cntr_d = '0;
            cnt_a_d     = '0;
            cnt_b_d     = '0;
            cnt_ab_d    = '0;
        end else if (gate_end) begin
            gate_cntr_d = '0;
            cnt_a_d     = '0;
            cnt_b_d     = '0;
            cnt_ab_d    = '0;
            gate_idx_d  = gate_idx_q + CNT_W'(1);
        end else begin
            gate_cntr_d = gate_cntr_q + GATE_WIDTH'(1);
            cnt_a_d     = cnt_a_nxt;
            cnt_b_d     = cnt_b_nxt;
            cnt_ab_d    = cnt_ab_nxt;
        end

        // Single-entry output: load if free or emptying this cycle, else drop.
        if (gate_end) begin
            if (!tvalid_q || handshake) begin
                tdata_d  = {gate_idx_q, cnt_ab_nxt, cnt_b_nxt, cnt_a_nxt};
                tvalid_d = 1'b1;
            end else begin
                sts_d = sat_inc(sts_q, 1'b1);
            end
        end else if (handshake) begin
            tvalid_d = 1'b0;
        end
    end

    // State and data registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            test_q      <= '0;
            gate_cntr_q <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            cnt_ab_q    <= '0;
            gate_idx_q  <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            sts_q       <= '0;
        end else begin
            state_q     <= state_d;
            test_q      <= test;
            gate_cntr_q <= gate_cntr_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            cnt_ab_q    <= cnt_ab_d;
            gate_idx_q  <= gate_idx_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            sts_q       <= sts_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign sts           = sts_q;

endmodule

// File: tb/tb_detector_coincidence_counter.sv
// Self-checking bench for detector_coincidence_counter: table of gates with
// hand-derived result words, a scoreboard queue popped on every handshake,
// and hand-written sequences for backpressure, N = 0, run drop, saturation
// and asynchronous reset.
module tb_detector_coincidence_counter;

    logic        aclk;
    logic        aresetn;
    logic [1:0]  test;
    logic [32:0] cfg;
    logic [15:0] sts;

    detector_coincidence_counter_if m_axis ();

    detector_coincidence_counter #(.GATE_WIDTH(32)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .test    (test),
        .cfg     (cfg),
        .m_axis  (m_axis),
        .sts     (sts)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] exp_q[$];
    int          acc_cyc[$];

    typedef struct {
        int unsigned n;
        int          na;
        int          nb;
        int          nab;
        logic [63:0] exp_word;
    } gate_vec_t;

    gate_vec_t vecs[6];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Scoreboard: inspect the bus just before each rising edge.
    always begin
        @(negedge aclk);
        #1;
        if (aresetn && m_axis.tvalid && m_axis.tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%h expected none", m_axis.tdata);
            end else begin
                check("word", m_axis.tdata, exp_q.pop_front());
            end
            acc_cyc.push_back(cyc);
        end
    end

    // Drives one gate's worth of samples (len cycles). Pulses are one cycle
    // high every 4 cycles: first nab coincident, then A-only, then B-only.
    task automatic play(input int unsigned n, input int na, input int nb, input int nab, input int len);
        int total;
        total = na + nb - nab;
        for (int c = 0; c < len; c++) begin
            @(negedge aclk);
            cfg = {1'b1, n};
            if ((c % 4 == 0) && (c / 4 < total)) begin
                if (c / 4 < nab)     test = 2'b11;
                else if (c / 4 < na) test = 2'b01;
                else                 test = 2'b10;
            end else begin
                test = 2'b00;
            end
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        check({"drain_", name}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        int gap;
        int t;
        logic [63:0] held;

        aresetn       = 1'b0;
        test          = 2'b00;
        cfg           = '0;
        m_axis.tready = 1'b0;

        vecs[0] = '{99, 5, 3, 2, 64'h0000_0002_0003_0005};
        vecs[1] = '{99, 0, 0, 0, 64'h0001_0000_0000_0000};
        vecs[2] = '{99, 7, 7, 7, 64'h0002_0007_0007_0007};
        vecs[3] = '{49, 1, 4, 0, 64'h0003_0000_0004_0001};
        vecs[4] = '{ 9, 2, 0, 0, 64'h0004_0000_0000_0002};
        vecs[5] = '{19, 3, 3, 1, 64'h0005_0001_0003_0003};

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("rst_tdata",  m_axis.tdata,       64'd0);
        check("rst_sts",    64'(sts),           64'd0);
        aresetn = 1'b1;
        m_axis.tready = 1'b1;
        repeat (5) @(negedge aclk);
        check("idle_tvalid", 64'(m_axis.tvalid), 64'd0);

        // Back-to-back gates from the table
        foreach (vecs[i]) exp_q.push_back(vecs[i].exp_word);
        base = acc_cyc.size();
        @(negedge aclk);
        cfg  = {1'b1, vecs[0].n};
        test = 2'b00;
        foreach (vecs[i]) play(vecs[i].n, vecs[i].na, vecs[i].nb, vecs[i].nab, int'(vecs[i].n) + 1);
        @(negedge aclk);
        cfg  = '0;
        test = 2'b00;
        drain("table");
        if (acc_cyc.size() >= base + 4) begin
            check("period_0_1", 64'(acc_cyc[base+1] - acc_cyc[base]),   64'd100);
            check("period_1_2", 64'(acc_cyc[base+2] - acc_cyc[base+1]), 64'd100);
            check("period_2_3", 64'(acc_cyc[base+3] - acc_cyc[base+2]), 64'd50);
        end else begin
            check("table_word_count", 64'(acc_cyc.size() - base), 64'd6);
        end

        // N = 0: every cycle is a gate end, simultaneous handshake and load
        for (int g = 0; g < 10; g++)
            exp_q.push_back({16'(g), 16'h0000, (g == 3) ? 16'h0001 : 16'h0000, 16'h0000});
        @(negedge aclk);
        cfg  = {1'b1, 32'd0};
        test = 2'b00;
        gap  = 0;
        for (int g = 0; g < 10; g++) begin
            @(negedge aclk);
            test = (g == 3) ? 2'b10 : 2'b00;
            if (g >= 1 && m_axis.tvalid !== 1'b1) gap++;
        end
        @(negedge aclk);
        cfg  = '0;
        test = 2'b00;
        drain("n0");
        check("n0_tvalid_gaps", 64'(gap), 64'd0);
        check("n0_sts",         64'(sts), 64'd0);

        // Run dropped mid-gate, idle pulse ignored, then restart
        @(negedge aclk);
        cfg  = {1'b1, 32'd999};
        test = 2'b00;
        play(999, 3, 0, 0, 500);
        @(negedge aclk);
        cfg  = '0;
        test = 2'b00;
        @(negedge aclk);
        test = 2'b01;
        @(negedge aclk);
        test = 2'b00;
        repeat (3) @(negedge aclk);
        exp_q.push_back(64'h0000_0000_0002_0000);
        @(negedge aclk);
        cfg = {1'b1, 32'd9};
        play(9, 0, 2, 0, 10);
        @(negedge aclk);
        cfg  = '0;
        test = 2'b00;
        drain("rundrop");
        check("rundrop_sts", 64'(sts), 64'd0);

        // Backpressure: first word held while three later words are dropped
        exp_q.push_back(64'h0000_0000_0001_0002);
        exp_q.push_back(64'h0004_0000_0000_0000);
        m_axis.tready = 1'b0;
        @(negedge aclk);
        cfg  = {1'b1, 32'd9};
        test = 2'b00;
        play(9, 2, 1, 0, 10);
        t = 0;
        while (m_axis.tvalid !== 1'b1 && t < 100) begin
            @(negedge aclk);
            t++;
        end
        check("bp_first_valid", 64'(m_axis.tvalid), 64'd1);
        held = m_axis.tdata;
        gap  = 0;
        repeat (35) begin
            @(negedge aclk);
            if (m_axis.tdata !== held || m_axis.tvalid !== 1'b1) gap++;
        end
        check("bp_held_stable", 64'(gap), 64'd0);
        check("bp_held_word",   held,     64'h0000_0000_0001_0002);
        check("bp_sts",         64'(sts), 64'd3);
        m_axis.tready = 1'b1;
        drain("bp");
        cfg = '0;
        repeat (3) @(negedge aclk);
        check("bp_sts_after", 64'(sts), 64'd3);

        // Saturation of cnt_a
        exp_q.push_back(64'h0000_0000_0000_FFFF);
        @(negedge aclk);
        cfg  = {1'b1, 32'd131999};
        test = 2'b00;
        for (int c = 0; c < 132000; c++) begin
            @(negedge aclk);
            test = (c % 2 == 1) ? 2'b01 : 2'b00;
        end
        @(negedge aclk);
        cfg  = '0;
        test = 2'b00;
        drain("sat");

        // Asynchronous reset mid-gate with a word pending
        m_axis.tready = 1'b0;
        @(negedge aclk);
        cfg  = {1'b1, 32'd4};
        test = 2'b00;
        play(4, 1, 1, 1, 5);
        repeat (15) @(negedge aclk);
        check("pre_rst_tvalid", 64'(m_axis.tvalid), 64'd1);
        check("pre_rst_tdata",  m_axis.tdata,       64'h0000_0001_0001_0001);
        #2;
        aresetn = 1'b0;
        cfg     = '0;
        #1;
        check("arst_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("arst_tdata",  m_axis.tdata,       64'd0);
        check("arst_sts",    64'(sts),           64'd0);
        @(negedge aclk);
        aresetn       = 1'b1;
        m_axis.tready = 1'b1;
        gap = 0;
        repeat (20) begin
            @(negedge aclk);
            if (m_axis.tvalid !== 1'b0) gap++;
        end
        check("post_rst_no_output", 64'(gap), 64'd0);
        check("post_rst_sts",       64'(sts), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
